// File: rtl/accum_drain.sv
// Drains a range of accumulator rows into a 4-deep valid/ready output FIFO, with an optional clear at the end.
// Optional build macro: ACCUM_DRAIN_RELU_EN zeroes negative lanes as rows enter the FIFO.
module accum_drain #(
  parameter  int DATA_WIDTH     = 16,
  parameter  int MAX_OUT_ROWS   = 128,
  parameter  int MAX_OUT_COLS   = 128,
  parameter  int SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int AW             = $clog2(NUM_ACCUM_ROWS),
  localparam int RW             = SYS_ARR_COLS * DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_rows,
  input  logic          clear_after,
  output logic          busy,
  output logic          done,
  output logic          accum_rd_en,
  output logic [AW-1:0] accum_rd_addr,
  input  logic [RW-1:0] accum_rd_data,
  output logic          accum_clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          out_last
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [AW:0]   MAX_ROWS  = (AW+1)'(NUM_ACCUM_ROWS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ACCUM_ROWS - 1);

  logic [2:0]    state;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   issue_left;
  logic [AW:0]   start_rows;
  logic          clear_flag;
  logic          pending;
  logic          pending_last;
  logic          rd_fire;
  logic          push;
  logic          pop;
  logic [3:0]    in_flight;
  logic [RW-1:0] push_data;

  logic [RW-1:0] fifo_data [4];
  logic [3:0]    fifo_last;
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    fifo_count;

  always_comb begin
    start_rows = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  end

  // A read is only issued when the FIFO is guaranteed a free slot for its returning data.
  always_comb begin
    in_flight = {1'b0, fifo_count} + {3'b000, pending};
    rd_fire   = (state == ST_READ) && (in_flight < 4'd4);
    push      = pending;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    push_data = accum_rd_data;
`ifdef ACCUM_DRAIN_RELU_EN
    for (int j = 0; j < SYS_ARR_COLS; j++) begin
      if (accum_rd_data[j*DATA_WIDTH + DATA_WIDTH - 1]) begin
        push_data[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_addr      <= '0;
      issue_left   <= '0;
      clear_flag   <= 1'b0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= rd_fire;
      pending_last <= rd_fire && (issue_left == (AW+1)'(1));
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr    <= base_addr;
            issue_left <= start_rows;
            clear_flag <= clear_after;
            if (start_rows != '0)  state <= ST_READ;
            else if (clear_after)  state <= ST_CLEAR;
            else                   state <= ST_DONE;
          end
        end
        ST_READ: begin
          if (rd_fire) begin
            rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
            issue_left <= issue_left - (AW+1)'(1);
            if (issue_left == (AW+1)'(1)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pop && out_last) state <= clear_flag ? ST_CLEAR : ST_DONE;
        end
        ST_CLEAR: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Row storage needs no reset; validity is tracked entirely by fifo_count.
  always_ff @(posedge clock) begin
    if (push) fifo_data[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
    end else begin
      if (push) begin
        fifo_last[wr_ptr] <= pending_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    accum_clear   = (state == ST_CLEAR);
    accum_rd_en   = rd_fire;
    accum_rd_addr = rd_addr;
    out_valid     = (fifo_count != 3'd0);
    out_data      = out_valid ? fifo_data[rd_ptr] : '0;
    out_last      = out_valid && fifo_last[rd_ptr];
  end

endmodule
